mac_arbiter: RTL and testbench
==============================

MAC_ARBITER -- requirements
Module: mac_arbiter

Interface
REQ-001 SHALL have parameter DW, default 5, operand width.
REQ-002 SHALL have parameter RW, default 16, accumulator result width.
REQ-003 SHALL have parameter CLR_CYCLES, default 1, number of cycles mac_nreset_o is held low before each job (range 1-15).
REQ-004 arb_clk_i  in  1  single clock; all state on its rising edge.
REQ-005 arb_reset_i  in  1  reset, asynchronous, active-high.
REQ-006 arb_req_i  in  2  per-requester valid; bit i means requester i presents an operand pair.
REQ-007 arb_a0_i, arb_b0_i, arb_a1_i, arb_b1_i  in  DW each  multiplicand/multiplier of requester 0 and requester 1.
REQ-008 arb_last_i  in  2  bit i marks requester i's current pair as the final pair of its job.
REQ-009 arb_ack_o  out  2  one-cycle pulse; bit i means requester i's pair was consumed this cycle.
REQ-010 arb_done_o  out  2  one-cycle pulse; bit i means requester i's job result is valid on arb_result_o.
REQ-011 arb_result_o  out  RW  captured job result, held until the next done pulse.
REQ-012 arb_busy_o  out  1  high in every state except IDLE.
REQ-013 arb_owner_o  out  1  index of the current or most recent owner.
REQ-014 arb_err_o  out  1  sticky protocol error flag.
REQ-015 mac_multiplicand_o, mac_multiplier_o  out  DW each  operands to the MAC.
REQ-016 mac_nreset_o  out  1  active-low accumulator clear to the MAC.
REQ-017 mac_fetch_i  in  1  MAC is sampling operands this cycle.
REQ-018 mac_update_i  in  1  one-cycle pulse per completed accumulate.
REQ-019 mac_result_i  in  RW  MAC accumulated result.

Function
REQ-020 SHALL implement an FSM with states IDLE, CLEAR, BUSY, DRAIN, DONE.
REQ-021 IDLE: if any arb_req_i bit is set, the FSM SHALL register the owner and go to CLEAR; if both are set, the owner is the requester not granted last (round-robin); after reset, requester 0 wins.
REQ-022 CLEAR: mac_nreset_o SHALL be 0 for exactly CLR_CYCLES cycles, then the FSM SHALL go to BUSY; mac_nreset_o SHALL be 1 in every other state.
REQ-023 BUSY/DRAIN/DONE: mac operands SHALL be a combinational mux of the owner's a/b inputs; in IDLE and CLEAR they SHALL be 0.
REQ-024 BUSY: arb_ack_o[owner] SHALL pulse in any cycle with mac_fetch_i=1 and arb_req_i[owner]=1; it SHALL never pulse for the non-owner.
REQ-025 An ack with arb_last_i[owner]=1 SHALL move the FSM to DRAIN; no further acks SHALL occur for the job.
REQ-026 An 8-bit outstanding counter SHALL increment on each ack and decrement on each mac_update_i pulse; if both occur in the same cycle, it SHALL be unchanged.
REQ-027 Acks SHALL be suppressed while outstanding=255 (stall, no wrap).
REQ-028 A mac_update_i pulse while outstanding=0 SHALL leave the counter at 0 and set arb_err_o.
REQ-029 DRAIN: when outstanding=0, the FSM SHALL capture mac_result_i into arb_result_o and go to DONE.
REQ-030 DONE: arb_done_o[owner] SHALL pulse for this one cycle, the round-robin pointer SHALL record the owner, and the FSM SHALL go to IDLE.
REQ-031 If the owner drops arb_req_i mid-job without last, the FSM SHALL remain in BUSY holding the MAC (no abort, no timeout).
REQ-032 A non-owner request SHALL wait and SHALL be granted in the IDLE cycle following DONE.
REQ-033 Grant-to-first-possible-ack latency SHALL be 1 + CLR_CYCLES cycles.

Reset
REQ-034 While arb_reset_i=1 the block SHALL hold: FSM in IDLE; arb_ack_o, arb_done_o, arb_result_o, arb_busy_o, arb_owner_o, arb_err_o all 0; outstanding 0; pointer favours requester 0; mac_nreset_o 0; mac operands 0.
REQ-035 Reset asserted mid-job SHALL take effect asynchronously and discard the job without a done pulse.
REQ-036 After release, arb_err_o SHALL be cleared only by reset.

Verification
REQ-037 Req0 job of 3 pairs (2x3, 4x5, 1x7, last on the third), fetch every other cycle, update 2 cycles after each ack -> 3 acks on bit 0, mac_nreset_o low 1 cycle before the first, done[0] pulse with arb_result_o=33 after the 3rd update.
REQ-038 Both requests set in the same IDLE cycle after reset -> owner 0 first; requester 1 granted immediately after done[0]; a third job on requester 0 is granted only after done[1].
REQ-039 Ack and update in the same cycle with outstanding=1 -> outstanding stays 1, no error.
REQ-040 Spurious mac_update_i in IDLE -> arb_err_o=1, sticky through later jobs, cleared by reset.
REQ-041 Reset pulse in BUSY after 2 acks -> all outputs 0 immediately, no done pulse, next request starts with CLEAR.
REQ-042 Owner drops req for 5 cycles mid-job while requester 1 requests -> no ack to either, owner unchanged, job resumes when req returns.

Source files
------------

// File: rtl/mac_arbiter.sv
// mac_arbiter: round-robin arbiter granting one of two requesters exclusive use of a shared MAC for a job.
// Ports: arb_* face the two requesters (req/operands/last in, ack/done/result/busy/owner/err out);
// mac_* face the MAC (operands and active-low clear out, fetch/update/result in).
module mac_arbiter #(
  parameter int DW = 5,
  parameter int RW = 16,
  parameter int CLR_CYCLES = 1
) (
  input  logic          arb_clk_i,
  input  logic          arb_reset_i,
  input  logic [1:0]    arb_req_i,
  input  logic [DW-1:0] arb_a0_i,
  input  logic [DW-1:0] arb_b0_i,
  input  logic [DW-1:0] arb_a1_i,
  input  logic [DW-1:0] arb_b1_i,
  input  logic [1:0]    arb_last_i,
  output logic [1:0]    arb_ack_o,
  output logic [1:0]    arb_done_o,
  output logic [RW-1:0] arb_result_o,
  output logic          arb_busy_o,
  output logic          arb_owner_o,
  output logic          arb_err_o,
  output logic [DW-1:0] mac_multiplicand_o,
  output logic [DW-1:0] mac_multiplier_o,
  output logic          mac_nreset_o,
  input  logic          mac_fetch_i,
  input  logic          mac_update_i,
  input  logic [RW-1:0] mac_result_i
);
  typedef enum logic [2:0] {IDLE, CLEAR, BUSY, DRAIN, DONE} state_t;
  state_t state;
  logic owner, last_grant, ack, live;
  logic [3:0] clr_cnt;
  logic [7:0] outstanding;
  // a pair is consumed only while the counter has room, so it never wraps
  assign ack = state == BUSY && mac_fetch_i && arb_req_i[owner] && outstanding != 8'hff;
  assign live = state == BUSY || state == DRAIN || state == DONE;
  assign arb_ack_o = {ack & owner, ack & ~owner};
  assign arb_done_o = {state == DONE && owner, state == DONE && !owner};
  assign arb_busy_o = state != IDLE;
  assign arb_owner_o = owner;
  assign mac_multiplicand_o = !live ? '0 : owner ? arb_a1_i : arb_a0_i;
  assign mac_multiplier_o = !live ? '0 : owner ? arb_b1_i : arb_b0_i;
  // gated with reset so the MAC is held cleared while the arbiter is in reset
  assign mac_nreset_o = state != CLEAR && !arb_reset_i;
  always_ff @(posedge arb_clk_i or posedge arb_reset_i) begin
    if (arb_reset_i) begin
      state <= IDLE;
      owner <= 1'b0;
      last_grant <= 1'b1;
      clr_cnt <= '0;
      outstanding <= '0;
      arb_result_o <= '0;
      arb_err_o <= 1'b0;
    end else begin
      if (mac_update_i && outstanding == 8'd0) arb_err_o <= 1'b1;
      outstanding <= ack && !mac_update_i ? outstanding + 8'd1 :
                     !ack && mac_update_i && outstanding != 8'd0 ? outstanding - 8'd1 : outstanding;
      case (state)
        IDLE: if (|arb_req_i) begin
          owner <= &arb_req_i ? ~last_grant : arb_req_i[1];
          clr_cnt <= 4'(CLR_CYCLES - 1);
          state <= CLEAR;
        end
        CLEAR: if (clr_cnt == 4'd0) state <= BUSY; else clr_cnt <= clr_cnt - 4'd1;
        BUSY: if (ack && arb_last_i[owner]) state <= DRAIN;
        DRAIN: if (outstanding == 8'd0) begin
          arb_result_o <= mac_result_i;
          state <= DONE;
        end
        DONE: begin
          last_grant <= owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_arbiter.sv
// tb_mac_arbiter: directed self-checking bench for mac_arbiter with a small behavioural MAC.
module tb_mac_arbiter;
  logic clk = 0, rst = 1;
  logic [1:0] req = 0, last = 0, ack, done;
  logic [4:0] a0 = 7, b0 = 7, a1 = 9, b1 = 9, mcand, mplier;
  logic fetch = 0, upd = 0, busy, owner, err, nrst;
  logic [15:0] result, acc = 0;
  int checks = 0, failures = 0, n = 0;

  always #5 clk = ~clk;

  // behavioural MAC: clears while nreset is low, accumulates each consumed pair
  always @(posedge clk)
    if (!nrst) acc <= 0;
    else if (fetch && |ack) acc <= acc + 16'(mcand) * 16'(mplier);

  mac_arbiter dut (
    .arb_clk_i(clk), .arb_reset_i(rst), .arb_req_i(req),
    .arb_a0_i(a0), .arb_b0_i(b0), .arb_a1_i(a1), .arb_b1_i(b1),
    .arb_last_i(last), .arb_ack_o(ack), .arb_done_o(done), .arb_result_o(result),
    .arb_busy_o(busy), .arb_owner_o(owner), .arb_err_o(err),
    .mac_multiplicand_o(mcand), .mac_multiplier_o(mplier), .mac_nreset_o(nrst),
    .mac_fetch_i(fetch), .mac_update_i(upd), .mac_result_i(acc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set(input logic [1:0] r, input logic [1:0] l, input logic f, input logic u);
    req = r; last = l; fetch = f; upd = u;
    #1;
  endtask

  initial begin
    set(2'b11, 2'b11, 1, 1);
    chk("rst_ack", ack, 0); chk("rst_done", done, 0); chk("rst_result", result, 0);
    chk("rst_busy", busy, 0); chk("rst_owner", owner, 0); chk("rst_err", err, 0);
    chk("rst_nrst", nrst, 0); chk("rst_mcand", mcand, 0); chk("rst_mplier", mplier, 0);
    tick; set(0, 0, 0, 0); tick;
    rst = 0;
    // three-pair job on requester 0, fetch every other cycle, update two cycles after each ack
    a0 = 2; b0 = 3;
    set(2'b01, 0, 0, 0); chk("idle_busy", busy, 0); chk("idle_nrst", nrst, 1); chk("idle_mcand", mcand, 0); tick;
    set(2'b01, 0, 1, 0); chk("clr_nrst", nrst, 0); chk("clr_ack", ack, 0); chk("clr_busy", busy, 1);
    chk("clr_owner", owner, 0); chk("clr_mcand", mcand, 0); tick;
    set(2'b01, 0, 1, 0); chk("b0_ack", ack, 2'b01); chk("b0_mcand", mcand, 2); chk("b0_mplier", mplier, 3); chk("b0_nrst", nrst, 1); tick;
    a0 = 4; b0 = 5;
    set(2'b01, 0, 0, 0); chk("b1_ack", ack, 0); tick;
    set(2'b01, 0, 1, 1); chk("b2_ack", ack, 2'b01); tick;
    a0 = 1; b0 = 7;
    set(2'b01, 2'b01, 0, 0); tick;
    set(2'b01, 2'b01, 1, 1); chk("b4_ack", ack, 2'b01); tick;
    set(2'b01, 2'b01, 1, 0); chk("drain_noack", ack, 0); chk("drain_busy", busy, 1); tick;
    set(0, 0, 0, 1); chk("drain_done", done, 0); tick;
    set(0, 0, 0, 0); chk("drain2_done", done, 0); tick;
    chk("done0", done, 2'b01); chk("result33", result, 33); chk("same_cycle_err", err, 0); tick;
    chk("after_busy", busy, 0); chk("after_done", done, 0); chk("held_result", result, 33);
    // spurious update in IDLE
    set(0, 0, 0, 1); tick; set(0, 0, 0, 0); chk("err_set", err, 1);
    tick; chk("err_sticky", err, 1);
    rst = 1; #1; chk("err_rst", err, 0); tick; rst = 0;
    // simultaneous requests after reset: 0 first, then 1, then 0 again
    a0 = 6; b0 = 3; a1 = 3; b1 = 4;
    set(2'b11, 0, 0, 0); tick;
    chk("rr_owner0", owner, 0); tick;
    set(2'b11, 2'b01, 1, 0); chk("rr_ack0", ack, 2'b01); chk("rr_mcand0", mcand, 6); tick;
    set(2'b11, 0, 0, 1); tick;
    set(2'b11, 0, 0, 0); tick;
    chk("rr_done0", done, 2'b01); chk("rr_result0", result, 18); tick;
    chk("rr_idle", busy, 0); tick;
    chk("rr_owner1", owner, 1); tick;
    set(2'b11, 2'b10, 1, 0); chk("rr_ack1", ack, 2'b10); chk("rr_mcand1", mcand, 3); chk("rr_mplier1", mplier, 4); tick;
    set(2'b11, 0, 0, 1); tick;
    set(2'b11, 0, 0, 0); chk("rr_hold1", owner, 1); tick;
    chk("rr_done1", done, 2'b10); chk("rr_result1", result, 12); chk("err_still0", err, 0); tick;
    tick;
    chk("rr_owner0_again", owner, 0); tick;
    // owner drops its request while requester 1 keeps asking
    a0 = 2; b0 = 2;
    for (int i = 0; i < 5; i++) begin
      set(2'b10, 0, 1, 0); chk("drop_ack", ack, 0); chk("drop_owner", owner, 0); chk("drop_busy", busy, 1); tick;
    end
    set(2'b11, 2'b01, 1, 0); chk("resume_ack", ack, 2'b01); tick;
    set(2'b10, 0, 0, 1); tick;
    set(2'b10, 0, 0, 0); tick;
    chk("resume_done", done, 2'b01); chk("resume_result", result, 4); tick;
    tick;
    chk("stall_owner", owner, 1); tick;
    // outstanding saturates at 255: acks stall until an update frees a slot
    a1 = 1; b1 = 1;
    for (int i = 0; i < 255; i++) begin
      set(2'b10, 0, 1, 0); n += int'(ack[1]); tick;
    end
    chk("stall_count", n, 255);
    set(2'b10, 0, 1, 0); chk("stall_ack", ack, 0); tick;
    set(2'b10, 0, 1, 1); chk("stall_ack_upd", ack, 0); tick;
    set(2'b10, 0, 1, 0); chk("stall_release", ack, 2'b10); chk("stall_err", err, 0); tick;
    rst = 1; #1; chk("stall_rst_busy", busy, 0); tick; rst = 0;
    // reset in BUSY after two acks discards the job
    a1 = 3; b1 = 3;
    set(2'b10, 0, 0, 0); tick;
    tick;
    set(2'b10, 0, 1, 0); chk("mid_ack1", ack, 2'b10); tick;
    chk("mid_ack2", ack, 2'b10); tick;
    rst = 1; #1;
    chk("mid_busy", busy, 0); chk("mid_ack", ack, 0); chk("mid_owner", owner, 0); chk("mid_nrst", nrst, 0);
    chk("mid_mcand", mcand, 0); chk("mid_result", result, 0); chk("mid_done", done, 0);
    tick; rst = 0;
    set(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("mid_nodone", done, 0); tick;
    end
    set(2'b01, 0, 1, 0); tick;
    chk("restart_nrst", nrst, 0); chk("restart_ack", ack, 0); chk("restart_busy", busy, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
